mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one external memory port between instruction fetch (IF) and data access (MEM).
//  Sits between the pipeline stages and a unified variable-latency memory.
//  Arbitrates, then captures the winner's command and drives it on the port.
//  Returns read data plus a one-cycle done pulse to the winner; one transaction in flight.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive data grants, while fetch waits, before fetch is forced next
//  CNT_W         3  width of starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   asynchronous, active-low reset
//  if_req     in   1   fetch request; held high until if_done
//  if_addr    in   32  fetch address, word aligned
//  if_rdata   out  32  fetch read data, valid while if_done=1
//  if_done    out  1   one-cycle completion pulse for fetch
//  d_req      in   1   data request; held high until d_done
//  d_we       in   1   1=store, 0=load
//  d_addr     in   32  data address
//  d_wdata    in   32  store data, already lane-aligned
//  d_mask     in   4   byte-lane write mask
//  d_rdata    out  32  load data, valid while d_done=1
//  d_done     out  1   one-cycle completion pulse for data
//  mem_req    out  1   port command valid
//  mem_we     out  1   port write enable
//  mem_addr   out  32  port address
//  mem_wdata  out  32  port write data
//  mem_mask   out  4   port byte mask; 4'hF for fetch
//  mem_ready  in   1   port accepts command this cycle (mem_req & mem_ready = handshake)
//  mem_rvalid in   1   response valid: read data or write ack, one per accepted command
//  mem_rdata  in   32  port read data
// BEHAVIOUR
//  - FSM states: IDLE, REQ, WAIT.
//    - IDLE: arbitrate.
//    - REQ: mem_req=1; held until mem_ready.
//    - WAIT: wait for mem_rvalid, then return to IDLE.
//  - Reset (async, reset=0): state=IDLE, starvation counter=0.
//    All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_mask, if_done, d_done, if_rdata, d_rdata.
//  - All outputs are registered.
//  - Arbitration in IDLE: a requester whose done is high this cycle is masked out.
//    This stops a stale re-grant in the same cycle the requester drops req.
//  - Priority:
//    - Data wins if d_req=1, unless if_req=1 and starve_cnt==STARVE_LIMIT; then fetch wins.
//    - Only one requester active: it wins.
//  - Grant cycle: capture the winner's command into the mem_* registers; next state REQ.
//    - Fetch grant: mem_we=0, mem_mask=4'hF, mem_wdata=0.
//  - starve_cnt:
//    - +1 on each data grant while if_req=1, saturating at STARVE_LIMIT.
//    - Cleared on a fetch grant, or in IDLE when if_req=0.
//  - REQ: mem_* stay stable until mem_ready=1. On handshake: mem_req drops to 0 next cycle; state WAIT.
//  - WAIT: on mem_rvalid=1:
//    - Latch mem_rdata into the winner's rdata.
//    - Assert the winner's done for exactly the next cycle; state IDLE.
//    - Stores also get rdata = mem_rdata; the data stage ignores it.
//  - Minimum latency, req sampled in cycle 0:
//    - mem_req=1 in cycle 1.
//    - With mem_ready in cycle 1 and mem_rvalid in cycle 2, done=1 in cycle 3.
//    - Back-to-back: the next grant is made in the done cycle; its mem_req rises the cycle after.
//  - mem_rvalid in IDLE or REQ is ignored (stale response). A response never completes twice.
//  - rdata registers hold their value after done falls; only the done pulse is meaningful.
//  - Dropping req before done is a protocol violation.
//    The arbiter completes the transaction anyway using the captured command.
//  - Reset mid-transaction: abort immediately to IDLE; no done pulse; any later mem_rvalid is ignored.
//  - Simultaneous if_req & d_req, both new: data granted first, fetch second, provided d_req
//    is not re-raised first. Starvation is bounded by STARVE_LIMIT.
// TESTING
//  1. Fetch only: if_req=1, addr=0x100; memory ready cycle 1, rvalid cycle 2, rdata=0x00000013
//     -> mem_mask=F, we=0; if_done=1 cycle 3 with if_rdata=0x13.
//  2. Store: d_req, we=1, addr=0x2004, wdata=0xAB00, mask=0010; mem_ready held 0 for 3 cycles
//     -> mem_* stable throughout; d_done exactly once, after rvalid.
//  3. Both raised in same cycle -> data granted first, fetch next.
//     No duplicate grant to data in its done cycle.
//  4. d_req held continuously with if_req=1, STARVE_LIMIT=4 -> 4 data grants, then a fetch grant.
//     starve_cnt then returns to 0.
//  5. Assert reset=0 in WAIT, then rvalid after release -> no done pulse; all outputs 0; state IDLE.
//  6. Random ready/rvalid delays 0-7 over 1000 mixed requests -> one done per request.
//     Addresses and data match a scoreboard; mem_req never high in WAIT.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access.
// One transaction in flight; data has priority, fetch is forced after a run of data grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_mask,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_mask,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e           state_r, state_nxt_s;
    logic [CNT_W-1:0] starve_cnt_r, starve_cnt_nxt_s;
    logic             owner_fetch_r, owner_fetch_nxt_s;
    logic             if_elig_s, d_elig_s, grant_fetch_s, grant_data_s;
    logic             mem_req_r, mem_req_nxt_s;
    logic             mem_we_r, mem_we_nxt_s;
    logic [31:0]      mem_addr_r, mem_addr_nxt_s;
    logic [31:0]      mem_wdata_r, mem_wdata_nxt_s;
    logic [3:0]       mem_mask_r, mem_mask_nxt_s;
    logic             if_done_r, if_done_nxt_s;
    logic             d_done_r, d_done_nxt_s;
    logic [31:0]      if_rdata_r, if_rdata_nxt_s;
    logic [31:0]      d_rdata_r, d_rdata_nxt_s;

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_mask  = mem_mask_r;
    assign if_done   = if_done_r;
    assign d_done    = d_done_r;
    assign if_rdata  = if_rdata_r;
    assign d_rdata   = d_rdata_r;

    // Arbitration: a requester completing this cycle is masked so its stale req is not re-granted.
    always_comb begin
        if_elig_s     = if_req & ~if_done_r;
        d_elig_s      = d_req & ~d_done_r;
        grant_fetch_s = 1'b0;
        grant_data_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (if_elig_s && (!d_elig_s || (starve_cnt_r == STARVE_MAX))) begin
                grant_fetch_s = 1'b1;
            end else if (d_elig_s) begin
                grant_data_s = 1'b1;
            end else begin
                grant_fetch_s = 1'b0;
                grant_data_s  = 1'b0;
            end
        end else begin
            grant_fetch_s = 1'b0;
            grant_data_s  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_fetch_s || grant_data_s) state_nxt_s = ST_REQ;
                else                                state_nxt_s = ST_IDLE;
            end
            ST_REQ: begin
                if (mem_ready) state_nxt_s = ST_WAIT;
                else           state_nxt_s = ST_REQ;
            end
            ST_WAIT: begin
                if (mem_rvalid) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_WAIT;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs, starvation counter and transaction owner.
    always_comb begin
        starve_cnt_nxt_s  = starve_cnt_r;
        owner_fetch_nxt_s = owner_fetch_r;
        mem_req_nxt_s     = mem_req_r;
        mem_we_nxt_s      = mem_we_r;
        mem_addr_nxt_s    = mem_addr_r;
        mem_wdata_nxt_s   = mem_wdata_r;
        mem_mask_nxt_s    = mem_mask_r;
        if_rdata_nxt_s    = if_rdata_r;
        d_rdata_nxt_s     = d_rdata_r;
        if_done_nxt_s     = 1'b0;
        d_done_nxt_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_fetch_s) begin
                    owner_fetch_nxt_s = 1'b1;
                    mem_req_nxt_s     = 1'b1;
                    mem_we_nxt_s      = 1'b0;
                    mem_addr_nxt_s    = if_addr;
                    mem_wdata_nxt_s   = 32'h0000_0000;
                    mem_mask_nxt_s    = 4'hF;
                    starve_cnt_nxt_s  = {CNT_W{1'b0}};
                end else if (grant_data_s) begin
                    owner_fetch_nxt_s = 1'b0;
                    mem_req_nxt_s     = 1'b1;
                    mem_we_nxt_s      = d_we;
                    mem_addr_nxt_s    = d_addr;
                    mem_wdata_nxt_s   = d_wdata;
                    mem_mask_nxt_s    = d_mask;
                    if (!if_req)                          starve_cnt_nxt_s = {CNT_W{1'b0}};
                    else if (starve_cnt_r == STARVE_MAX)  starve_cnt_nxt_s = STARVE_MAX;
                    else                                  starve_cnt_nxt_s = starve_cnt_r + CNT_ONE;
                end else if (!if_req) begin
                    starve_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    starve_cnt_nxt_s = starve_cnt_r;
                end
            end
            ST_REQ: begin
                if (mem_ready) mem_req_nxt_s = 1'b0;
                else           mem_req_nxt_s = 1'b1;
            end
            ST_WAIT: begin
                if (mem_rvalid && owner_fetch_r) begin
                    if_done_nxt_s  = 1'b1;
                    if_rdata_nxt_s = mem_rdata;
                end else if (mem_rvalid) begin
                    d_done_nxt_s  = 1'b1;
                    d_rdata_nxt_s = mem_rdata;
                end else begin
                    if_done_nxt_s = 1'b0;
                    d_done_nxt_s  = 1'b0;
                end
            end
            default: mem_req_nxt_s = 1'b0;
        endcase
    end

    // Output and bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r  <= {CNT_W{1'b0}};
            owner_fetch_r <= 1'b0;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= 32'h0000_0000;
            mem_wdata_r   <= 32'h0000_0000;
            mem_mask_r    <= 4'h0;
            if_done_r     <= 1'b0;
            d_done_r      <= 1'b0;
            if_rdata_r    <= 32'h0000_0000;
            d_rdata_r     <= 32'h0000_0000;
        end else begin
            starve_cnt_r  <= starve_cnt_nxt_s;
            owner_fetch_r <= owner_fetch_nxt_s;
            mem_req_r     <= mem_req_nxt_s;
            mem_we_r      <= mem_we_nxt_s;
            mem_addr_r    <= mem_addr_nxt_s;
            mem_wdata_r   <= mem_wdata_nxt_s;
            mem_mask_r    <= mem_mask_nxt_s;
            if_done_r     <= if_done_nxt_s;
            d_done_r      <= d_done_nxt_s;
            if_rdata_r    <= if_rdata_nxt_s;
            d_rdata_r     <= d_rdata_nxt_s;
        end
    end

endmodule
